// File: rtl/exponent_down.sv
// Multi-cycle left normalizer for the FP add/sub path: shifts the mantissa one bit per
// clock, decrementing the exponent, until the hidden bit is set or the value flushes to zero.
module exponent_down #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic [MANT_W-1:0] mant_in,
   output logic              busy,
   output logic              done,
   output logic [EXP_W-1:0]  exp_out,
   output logic [MANT_W-1:0] mant_out,
   output logic              zero_out,
   output logic [4:0]        shift_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [EXP_W-1:0]  exp_r_q, exp_r_d;
   logic [MANT_W-1:0] mant_r_q, mant_r_d;
   logic              zero_r_q, zero_r_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [EXP_W-1:0]  exp_out_q, exp_out_d;
   logic [MANT_W-1:0] mant_out_q, mant_out_d;
   logic              zero_out_q, zero_out_d;
   logic [4:0]        shift_cnt_q, shift_cnt_d;
   logic              done_q, done_d;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
      state_d     = state_q;
      exp_r_d     = exp_r_q;
      mant_r_d    = mant_r_q;
      zero_r_d    = zero_r_q;
      cnt_d       = cnt_q;
      exp_out_d   = exp_out_q;
      mant_out_d  = mant_out_q;
      zero_out_d  = zero_out_q;
      shift_cnt_d = shift_cnt_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               exp_r_d  = exp_in;
               mant_r_d = mant_in;
               zero_r_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (mant_r_q == '0 || exp_r_q == '0) begin
               exp_r_d  = '0;
               mant_r_d = '0;
               zero_r_d = 1'b1;
               state_d  = DONE;
            end else if (mant_r_q[MANT_W-1]) begin
               state_d = DONE;
            end else if (exp_r_q == EXP_W'(1)) begin
               // One more shift would take the exponent to 0, which is reserved for zero.
               exp_r_d  = '0;
               mant_r_d = '0;
               zero_r_d = 1'b1;
               state_d  = DONE;
            end else begin
               mant_r_d = {mant_r_q[MANT_W-2:0], 1'b0};
               exp_r_d  = exp_r_q - EXP_W'(1);
               cnt_d    = cnt_q + 5'd1;
            end
         end
         DONE: begin
            exp_out_d   = exp_r_q;
            mant_out_d  = mant_r_q;
            zero_out_d  = zero_r_q;
            shift_cnt_d = cnt_q;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q     <= IDLE;
         exp_r_q     <= '0;
         mant_r_q    <= '0;
         zero_r_q    <= 1'b0;
         cnt_q       <= '0;
         exp_out_q   <= '0;
         mant_out_q  <= '0;
         zero_out_q  <= 1'b0;
         shift_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_r_q     <= exp_r_d;
         mant_r_q    <= mant_r_d;
         zero_r_q    <= zero_r_d;
         cnt_q       <= cnt_d;
         exp_out_q   <= exp_out_d;
         mant_out_q  <= mant_out_d;
         zero_out_q  <= zero_out_d;
         shift_cnt_q <= shift_cnt_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign exp_out   = exp_out_q;
   assign mant_out  = mant_out_q;
   assign zero_out  = zero_out_q;
   assign shift_cnt = shift_cnt_q;

endmodule
